// File: rtl/agc_gain_controller_if.sv
// Sample stream from the gain scaler plus the AGC status/gain outputs returned to it.
interface agc_gain_controller_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] sample_in;
  logic                  sample_valid_in;
  logic [7:0]            gain_control;
  logic                  gain_update;
  logic [DATA_WIDTH-1:0] peak_level;
  logic                  level_valid;
  logic                  agc_locked;
  logic                  at_limit;

  modport master (
    output sample_in, sample_valid_in,
    input  gain_control, gain_update, peak_level, level_valid, agc_locked, at_limit
  );

  modport slave (
    input  sample_in, sample_valid_in,
    output gain_control, gain_update, peak_level, level_valid, agc_locked, at_limit
  );
endinterface

// File: rtl/agc_gain_controller.sv
// Closed-loop AGC: measures window peak magnitude of scaler output and steps the gain code
// to keep the peak between thr_low and thr_high, with a manual bypass when disabled.
module agc_gain_controller #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WIN_LOG2       = 8,
  parameter int unsigned SETTLE_SAMPLES = 16,
  parameter int unsigned MAX_SHIFT      = 7,
  parameter logic [7:0]  INIT_GAIN      = 8'h70
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  agc_enable,
  input  logic [7:0]            manual_gain,
  input  logic [DATA_WIDTH-1:0] thr_high,
  input  logic [DATA_WIDTH-1:0] thr_low,
  agc_gain_controller_if.slave  bus
);

  localparam int unsigned SetW    = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [2:0]  MaxS    = 3'(MAX_SHIFT);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_SAMPLES - 1);

  typedef enum logic [2:0] {StIdle, StSanitize, StMeasure, StDecide, StSettle} state_e;

  state_e                state_q, state_d;
  logic [7:0]            gain_q, gain_d;
  logic                  upd_q, upd_d;
  logic [DATA_WIDTH-1:0] peak_lvl_q, peak_lvl_d;
  logic                  lvl_vld_q, lvl_vld_d;
  logic                  locked_q, locked_d;
  logic [DATA_WIDTH-1:0] run_peak_q, run_peak_d;
  logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
  logic [SetW-1:0]       set_cnt_q, set_cnt_d;

  logic [DATA_WIDTH-1:0] mag;
  logic [3:0]            m;
  logic [2:0]            s;
  logic [7:0]            gain_up, gain_dn, gain_san, step;

  // Most negative input wraps to 2^(DATA_WIDTH-1), which is exactly its unsigned magnitude.
  assign mag = bus.sample_in[DATA_WIDTH-1] ? (~bus.sample_in + DATA_WIDTH'(1)) : bus.sample_in;
  assign m   = gain_q[7:4];
  assign s   = gain_q[2:0];

  always_comb begin
    gain_up = gain_q;
    if (m != 4'hF) begin
      gain_up[7:4] = m + 4'd1;
    end else if (s < MaxS) begin
      gain_up[7:4] = 4'd8;
      gain_up[2:0] = s + 3'd1;
    end

    gain_dn = gain_q;
    if (s != 3'd0 && m == 4'd8) begin
      gain_dn[7:4] = 4'hF;
      gain_dn[2:0] = s - 3'd1;
    end else if (m != 4'd0) begin
      gain_dn[7:4] = m - 4'd1;
    end else begin
      gain_dn = 8'h00;
    end

    gain_san = gain_q;
    if (gain_q[3]) begin
      gain_san = 8'h00;
    end else if (s > MaxS) begin
      gain_san[2:0] = MaxS;
    end else if (s != 3'd0 && m < 4'd8) begin
      gain_san[7:4] = 4'd8;
    end
  end

  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    upd_d      = 1'b0;
    peak_lvl_d = peak_lvl_q;
    lvl_vld_d  = 1'b0;
    locked_d   = locked_q;
    run_peak_d = run_peak_q;
    win_cnt_d  = win_cnt_q;
    set_cnt_d  = set_cnt_q;
    step       = gain_q;

    if (!agc_enable) begin
      state_d    = StIdle;
      gain_d     = manual_gain;
      upd_d      = (manual_gain != gain_q);
      locked_d   = 1'b0;
      run_peak_d = '0;
      win_cnt_d  = '0;
      set_cnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StSanitize;
        StSanitize: begin
          gain_d  = gain_san;
          upd_d   = (gain_san != gain_q);
          state_d = StMeasure;
        end
        StMeasure: begin
          if (bus.sample_valid_in) begin
            if (mag > run_peak_q) run_peak_d = mag;
            win_cnt_d = win_cnt_q + WIN_LOG2'(1);
            if (win_cnt_q == '1) state_d = StDecide;
          end
        end
        StDecide: begin
          peak_lvl_d = run_peak_q;
          lvl_vld_d  = 1'b1;
          run_peak_d = '0;
          win_cnt_d  = '0;
          set_cnt_d  = '0;
          // DOWN wins even when the thresholds are inverted.
          if (run_peak_q > thr_high) begin
            step     = gain_dn;
            locked_d = 1'b0;
          end else if (run_peak_q < thr_low) begin
            step     = gain_up;
            locked_d = 1'b0;
          end else begin
            locked_d = 1'b1;
          end
          gain_d  = step;
          upd_d   = (step != gain_q);
          state_d = (step != gain_q) ? StSettle : StMeasure;
        end
        StSettle: begin
          if (bus.sample_valid_in) begin
            if (set_cnt_q == SetLast) begin
              set_cnt_d = '0;
              state_d   = StMeasure;
            end else begin
              set_cnt_d = set_cnt_q + SetW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gain_q     <= INIT_GAIN;
      upd_q      <= 1'b0;
      peak_lvl_q <= '0;
      lvl_vld_q  <= 1'b0;
      locked_q   <= 1'b0;
      run_peak_q <= '0;
      win_cnt_q  <= '0;
      set_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      upd_q      <= upd_d;
      peak_lvl_q <= peak_lvl_d;
      lvl_vld_q  <= lvl_vld_d;
      locked_q   <= locked_d;
      run_peak_q <= run_peak_d;
      win_cnt_q  <= win_cnt_d;
      set_cnt_q  <= set_cnt_d;
    end
  end

  assign bus.gain_control = gain_q;
  assign bus.gain_update  = upd_q;
  assign bus.peak_level   = peak_lvl_q;
  assign bus.level_valid  = lvl_vld_q;
  assign bus.agc_locked   = locked_q;
  assign bus.at_limit     = (gain_q == 8'h00) || (gain_q[7:4] == 4'hF && gain_q[2:0] == MaxS);

endmodule

// File: tb/tb_agc_gain_controller.sv
// Scoreboard bench for agc_gain_controller: each window pushes its expected decision,
// a negedge monitor pops and compares whenever level_valid pulses.
module tb_agc_gain_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        agc_enable;
  logic [7:0]  manual_gain;
  logic [31:0] thr_high;
  logic [31:0] thr_low;

  typedef struct packed {
    logic [31:0] peak;
    logic [7:0]  gain;
    logic        upd;
    logic        locked;
    logic        lim;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   upd_cnt = 0;
  int   u0;

  agc_gain_controller_if #(.DATA_WIDTH(32)) bus ();

  agc_gain_controller #(
    .DATA_WIDTH     (32),
    .WIN_LOG2       (4),
    .SETTLE_SAMPLES (16),
    .MAX_SHIFT      (7),
    .INIT_GAIN      (8'h70)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .agc_enable  (agc_enable),
    .manual_gain (manual_gain),
    .thr_high    (thr_high),
    .thr_low     (thr_low),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every level_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.gain_update) upd_cnt++;
      if (bus.level_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_level_valid actual=%h required=none", bus.peak_level);
        end else begin
          e = exp_q.pop_front();
          cmp("peak_level", bus.peak_level, e.peak);
          cmp("gain_control", 32'(bus.gain_control), 32'(e.gain));
          cmp("gain_update", 32'(bus.gain_update), 32'(e.upd));
          cmp("agc_locked", 32'(bus.agc_locked), 32'(e.locked));
          cmp("at_limit", 32'(bus.at_limit), 32'(e.lim));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] smp);
    bus.sample_in       = smp;
    bus.sample_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_valid_in = 1'b0;
  endtask

  task automatic window(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 16; i++) send(i[0] ? b : a);
  endtask

  task automatic expect_lv(input logic [31:0] peak, input logic [7:0] gain, input logic upd,
                           input logic locked, input logic lim);
    exp_t e;
    e.peak = peak; e.gain = gain; e.upd = upd; e.locked = locked; e.lim = lim;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    tick(3);
    while (exp_q.size() != 0 && n < 40) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_gain(input logic [7:0] g);
    agc_enable  = 1'b0;
    manual_gain = g;
    tick(2);
    agc_enable  = 1'b1;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst                 = 1'b1;
    agc_enable          = 1'b0;
    manual_gain         = 8'h70;
    thr_low             = 32'h0000_4000;
    thr_high            = 32'h0000_8000;
    bus.sample_in       = '0;
    bus.sample_valid_in = 1'b0;

    tick(3);
    at_neg();
    cmp("rst_gain", 32'(bus.gain_control), 32'h70);
    cmp("rst_update", 32'(bus.gain_update), 32'h0);
    cmp("rst_level_valid", 32'(bus.level_valid), 32'h0);
    cmp("rst_peak", bus.peak_level, 32'h0);
    cmp("rst_locked", 32'(bus.agc_locked), 32'h0);

    // Manual mode: one pulse, no AGC activity despite samples.
    u0 = upd_cnt;
    rst = 1'b0;
    manual_gain = 8'h81;
    for (int i = 0; i < 20; i++) send(32'h0000_0010);
    at_neg();
    cmp("manual_gain", 32'(bus.gain_control), 32'h81);
    cmp("manual_pulses", 32'(upd_cnt - u0), 32'd1);

    // Enable: sanitize keeps 0x81, then UP, settle ignores 16 loud samples, then HOLD.
    u0 = upd_cnt;
    agc_enable = 1'b1;
    tick(2);
    at_neg();
    cmp("sanitize_81", 32'(bus.gain_control), 32'h81);
    cmp("sanitize_81_pulses", 32'(upd_cnt - u0), 32'd0);
    expect_lv(32'h0000_1000, 8'h91, 1'b1, 1'b0, 1'b0);
    window(32'h0000_1000, 32'hFFFF_F000);
    drain();
    for (int i = 0; i < 16; i++) send(32'h7FFF_FFFF);
    expect_lv(32'h0000_6000, 8'h91, 1'b0, 1'b1, 1'b0);
    window(32'h0000_6000, 32'hFFFF_A000);
    drain();
    at_neg();
    cmp("hold_locked", 32'(bus.agc_locked), 32'h1);

    // DOWN within a shift band, and DOWN across a band boundary.
    set_gain(8'hF1);
    expect_lv(32'h0001_0000, 8'hE1, 1'b1, 1'b0, 1'b0);
    window(32'h0001_0000, 32'h0000_0100);
    drain();
    set_gain(8'h81);
    expect_lv(32'h0000_9000, 8'hF0, 1'b1, 1'b0, 1'b0);
    window(32'h0000_9000, 32'hFFFF_E000);
    drain();

    // Bit3 set sanitizes to 0x00; most negative sample; saturated DOWN.
    set_gain(8'h8C);
    at_neg();
    cmp("sanitize_bit3", 32'(bus.gain_control), 32'h00);
    expect_lv(32'h8000_0000, 8'h00, 1'b0, 1'b0, 1'b1);
    window(32'h8000_0000, 32'h8000_0000);
    drain();
    at_neg();
    cmp("min_at_limit", 32'(bus.at_limit), 32'h1);

    // Saturated UP goes straight back to MEASURE: the next window is not swallowed.
    set_gain(8'hF7);
    expect_lv(32'h0000_0100, 8'hF7, 1'b0, 1'b0, 1'b1);
    window(32'h0000_0100, 32'hFFFF_FF80);
    drain();
    expect_lv(32'h0000_6000, 8'hF7, 1'b0, 1'b1, 1'b1);
    window(32'h0000_6000, 32'h0000_6000);
    drain();

    // Drop enable mid-window: manual gain takes over, window aborted, peak_level kept.
    set_gain(8'h81);
    for (int i = 0; i < 8; i++) send(32'h0000_9000);
    agc_enable  = 1'b0;
    manual_gain = 8'h42;
    tick(2);
    at_neg();
    cmp("drop_gain", 32'(bus.gain_control), 32'h42);
    cmp("drop_peak_kept", bus.peak_level, 32'h0000_6000);
    cmp("drop_locked", 32'(bus.agc_locked), 32'h0);
    agc_enable = 1'b1;
    tick(2);
    at_neg();
    cmp("sanitize_m8", 32'(bus.gain_control), 32'h82);
    expect_lv(32'h0000_6000, 8'h82, 1'b0, 1'b1, 1'b0);
    window(32'h0000_6000, 32'hFFFF_A000);
    drain();

    // Reset in the middle of SETTLE.
    set_gain(8'h81);
    expect_lv(32'h0000_1000, 8'h91, 1'b1, 1'b0, 1'b0);
    window(32'h0000_1000, 32'hFFFF_F000);
    drain();
    for (int i = 0; i < 5; i++) send(32'h7FFF_FFFF);
    rst         = 1'b1;
    agc_enable  = 1'b0;
    manual_gain = 8'h70;
    tick(1);
    at_neg();
    cmp("rst2_gain", 32'(bus.gain_control), 32'h70);
    cmp("rst2_peak", bus.peak_level, 32'h0);
    cmp("rst2_locked", 32'(bus.agc_locked), 32'h0);
    cmp("rst2_update", 32'(bus.gain_update), 32'h0);
    rst = 1'b0;
    set_gain(8'h70);
    expect_lv(32'h0000_6000, 8'h70, 1'b0, 1'b1, 1'b0);
    window(32'h0000_6000, 32'h0000_6000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/agc_gain_controller.md
Name: agc_gain_controller

Overview:
- Closed-loop automatic gain controller that generates the 8-bit gain_control code consumed by adaptive_gain_scaler.
- Monitors the scaler's output samples (sample_out/sample_valid_out) and measures peak magnitude over a window of valid samples.
- Steps the gain code up or down to hold the peak between two programmable thresholds, then waits for the loop to settle.
- Sits beside the scaler in the receive datapath. A manual-gain bypass is available when AGC is disabled.

Parameters:
- DATA_WIDTH, 32, sample width; samples are signed two's complement.
- WIN_LOG2, 8, measurement window = 2^WIN_LOG2 valid samples.
- SETTLE_SAMPLES, 16, valid samples discarded after each gain change (must be ≥1).
- MAX_SHIFT, 7, maximum left-shift field value the AGC will produce (≤7).
- INIT_GAIN, 8'h70, gain_control value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- agc_enable  in  1  1 = closed loop; 0 = manual_gain drives the output.
- manual_gain  in  8  gain code used while agc_enable=0.
- thr_high  in  DATA_WIDTH  peak above this value steps the gain down (unsigned).
- thr_low  in  DATA_WIDTH  peak below this value steps the gain up (unsigned).
- sample_in  in  DATA_WIDTH  scaler output sample.
- sample_valid_in  in  1  sample qualifier.
- gain_control  out  8  code to the scaler: [7:4] = M (gain M+1), [3] = 1 right/0 left, [2:0] = shift S.
- gain_update  out  1  one-cycle pulse in the cycle gain_control takes a new value.
- peak_level  out  DATA_WIDTH  peak magnitude of the last completed window.
- level_valid  out  1  one-cycle pulse when peak_level is updated.
- agc_locked  out  1  1 when the last window decision was HOLD.
- at_limit  out  1  1 when gain_control is at min (8'h00) or max (M=15, S=MAX_SHIFT).

Behaviour:
- Reset values: gain_control=INIT_GAIN, gain_update=0, peak_level=0, level_valid=0, agc_locked=0, state=IDLE, counters=0.
- Magnitude = |sample| as unsigned DATA_WIDTH bits. The most negative value maps to 2^(DATA_WIDTH-1) with no overflow.
- States: IDLE, SANITIZE, MEASURE, DECIDE, SETTLE.
- IDLE (agc_enable=0):
  - gain_control <= manual_gain each cycle; gain_update pulses when the registered value changes.
  - Counters and running peak are cleared; agc_locked=0.
  - agc_enable=1 moves to SANITIZE.
- SANITIZE (1 cycle), forces the code into the AGC range:
  - If bit3=1, code becomes 8'h00.
  - Else if S>MAX_SHIFT, S becomes MAX_SHIFT.
  - Else if S>0 and M<8, M becomes 8.
  - gain_update pulses only if the code changed. Next state is MEASURE.
- MEASURE:
  - Each valid sample updates the running peak = max(peak, magnitude) and increments the window counter.
  - On the valid sample that completes 2^WIN_LOG2 samples, that sample is included and the state moves to DECIDE.
- DECIDE (1 cycle):
  - peak_level <= peak and level_valid pulses; running peak and counter are cleared.
  - If peak > thr_high: decision is DOWN. This takes priority, including when thr_low > thr_high.
  - Else if peak < thr_low: decision is UP.
  - Else: decision is HOLD.
- Gain update:
  - For UP or DOWN, gain_control updates in the DECIDE→next transition, with gain_update pulsing the cycle after DECIDE.
  - agc_locked is set on HOLD and cleared on UP/DOWN.
- Step rules (monotonic gain; valid range is M 0..15 at S=0 and M 8..15 at S>0):
  - UP: if M<15 then M+1; else if S<MAX_SHIFT then S+1 and M=8; else saturate, with no gain_update pulse.
  - DOWN: if S>0 and M=8 then S-1 and M=15; else if M>0 then M-1; else saturate at 8'h00, with no pulse.
- After DECIDE: SETTLE if the code changed, otherwise MEASURE (including saturated UP/DOWN).
- SETTLE: discard SETTLE_SAMPLES valid samples (not counted toward any window), then MEASURE.
- agc_enable dropping in any state:
  - Next cycle enters IDLE and aborts the window; peak_level is kept.
  - gain_control follows manual_gain from that cycle on.
- Reset asserted mid-window or mid-settle restores all reset values on the next clock edge.
- sample_valid_in=0 cycles are ignored in every state.
- Output latency: gain_update/new gain_control appear 2 cycles after the window-completing valid sample.

Test Plan:
- Reset with INIT_GAIN=8'h70 -> gain_control=8'h70, all pulses 0.
- agc_enable=0, manual_gain=8'h81 -> gain_control=8'h81 one cycle later with one gain_update pulse; no AGC steps follow.
- Enable with gain 8'h81 (WIN_LOG2=4, thr_low=32'h4000, thr_high=32'h8000):
  - SANITIZE -> 8'h81 kept.
  - A 16-sample window of ±32'h1000 -> UP -> 8'h91 and one gain_update pulse.
  - The next 16 valid samples are ignored (SETTLE).
- Gain 8'hF1, window peak 32'h10000 -> DOWN -> 8'hE1.
- Gain 8'h81, peak over thr_high -> DOWN -> 8'hF0.
- Gain 8'h00, window of 32'h80000000 (most negative sample) -> peak_level=32'h80000000, DOWN saturated, no pulse, at_limit=1.
- Gain 8'hF7 with peak below thr_low -> saturates at 8'hF7 with no gain_update, and the next state is MEASURE.
- Peak 32'h6000 with thr_low=32'h4000, thr_high=32'h8000 -> HOLD, agc_locked=1.
- Drop agc_enable mid-window -> IDLE, gain_control=manual_gain.
- Assert rst mid-SETTLE -> all reset values restored on the next clock edge.
